adaptive_intersection_ctrl: RTL and testbench
=============================================

Name: adaptive_intersection_ctrl

Overview:
Parametrised N-approach traffic-light controller. It counts vehicle arrivals per approach and serves approaches round-robin, skipping approaches with no waiting cars. Green time is stretched in proportion to each approach's queue. It runs on the 2 Hz tick domain and drives the light outputs, the status display and the servo logic. It replaces the fixed 4-way controller plus the separate per-approach counters.

Parameters:
N_PHASES, 4, number of approaches (2..8)
CNT_W, 14, width of each cumulative arrival counter
QUEUE_W, 5, width of each waiting-car queue counter
TIMER_W, 6, width of phase timer; must hold T_GREEN_MAX
T_GREEN_MIN, 10, base green duration in ticks (>=1)
T_GREEN_MAX, 30, green duration cap in ticks (>=T_GREEN_MIN)
T_PER_CAR, 2, extra green ticks per queued car
T_YELLOW, 4, yellow duration in ticks (>=1)
T_ALLRED, 2, all-red clearance duration in ticks (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle timing enable from the clock divider
detect  in  N_PHASES  vehicle detector levels, already synchronised
lights  out  3*N_PHASES  per approach i, bits [3i+2:3i] = {red,yellow,green}, active-high, one-hot
phase  out  max(1,clog2(N_PHASES))  index of the active approach
state  out  2  0=GREEN, 1=YELLOW, 2=ALLRED
timer  out  TIMER_W  ticks remaining in the current state
count_total  out  N_PHASES*CNT_W  cumulative arrivals; approach i in slice [i*CNT_W +: CNT_W]
queue  out  N_PHASES*QUEUE_W  waiting cars; approach i in slice [i*QUEUE_W +: QUEUE_W]

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high. All registers update on the clk rising edge. tick is ignored while rst is high.
- Reset values:
  - state=ALLRED, phase=N_PHASES-1, timer=T_ALLRED.
  - All lights red.
  - count_total=0, queue=0, detect history=0.
- Arrival detection:
  - arrival[i] = detect[i] & ~detect_q[i], evaluated every clk cycle, independent of tick.
  - Arrival effects are visible one cycle after the rising edge.
- count_total[i]: +1 on arrival, saturates at all-ones.
- queue[i]: +1 on arrival, saturates at 2^QUEUE_W-1.
  - The active approach's queue is cleared on the GREEN->YELLOW transition cycle.
  - If an arrival coincides with the clear, queue becomes 1.
- Timer:
  - Decrements only on tick.
  - When timer==1 and tick is high, the state transitions and timer reloads for the new state.
  - Each state therefore lasts exactly its loaded value in ticks.
- Transitions:
  - GREEN -> YELLOW: load T_YELLOW.
  - YELLOW -> ALLRED: load T_ALLRED.
  - ALLRED -> GREEN: select the next phase and load its green time.
- Next-phase select:
  - Search indices phase+1, phase+2, ... wrapping modulo N_PHASES, including phase itself last.
  - Pick the first index with queue!=0.
  - If all queues are zero, pick (phase+1) mod N_PHASES.
- Green time: min(T_GREEN_MAX, T_GREEN_MIN + T_PER_CAR*queue[new phase]).
  - Sampled from queue values in the transition cycle.
  - Computed at full internal width; no overflow before the clamp.
- Lights:
  - GREEN: active approach green, all others red.
  - YELLOW: active approach yellow, all others red.
  - ALLRED: every approach red.
  - Never more than one approach non-red.
- Reset mid-operation returns every output to its reset value the next cycle, regardless of tick or detect.

Optional Feature:
PREEMPT_EN
- Defined:
  - Adds ports preempt (in, 1) and preempt_phase (in, phase width).
  - preempt high while in GREEN with phase!=preempt_phase: the next cycle enters YELLOW with T_YELLOW loaded, regardless of tick.
  - preempt high at ALLRED expiry: the next phase is preempt_phase, overriding round-robin. Its green time follows the normal rule.
  - While preempt is high and phase==preempt_phase in GREEN, the timer holds.
- Undefined: these ports are absent and the behaviour is exactly as specified above.

Test Plan:
- Reset held 3 cycles, no cars -> all lights red, state=2, timer=2, phase=3; after 2 ticks phase=0 green with timer=10.
- No arrivals, defaults -> sequence per approach is green 10, yellow 4, all-red 2 ticks; phases 0,1,2,3,0; exactly one non-red approach at any time.
- 3 rising edges on detect[1] during phase 0 green -> queue[1]=3; phase 1 green timer=16; queue[1]=0 on its GREEN->YELLOW cycle; count_total[1]=3.
- 15 arrivals on approach 2 -> green=30 (clamped). detect held high for 100 cycles counts 1. 40 arrivals -> queue saturates at 31.
- Arrivals only on approach 3 while phase 0 green -> next green is phase 3, skipping 1 and 2. Arrival in the clear cycle -> queue=1.
- PREEMPT_EN: preempt=1, preempt_phase=2 during phase 0 green -> YELLOW next cycle, then ALLRED, then phase 2 green; timer frozen while preempt is held.

Source files
------------

// File: rtl/adaptive_intersection_ctrl.sv
// rtl/adaptive_intersection_ctrl.sv - N-approach adaptive round-robin traffic-light controller (optional PREEMPT_EN)
module adaptive_intersection_ctrl #(
    parameter int N_PHASES    = 4,
    parameter int CNT_W       = 14,
    parameter int QUEUE_W     = 5,
    parameter int TIMER_W     = 6,
    parameter int T_GREEN_MIN = 10,
    parameter int T_GREEN_MAX = 30,
    parameter int T_PER_CAR   = 2,
    parameter int T_YELLOW    = 4,
    parameter int T_ALLRED    = 2,
    localparam int PH_W       = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [N_PHASES-1:0]           detect,
`ifdef PREEMPT_EN
    input  logic                          preempt,
    input  logic [PH_W-1:0]               preempt_phase,
`endif
    output logic [3*N_PHASES-1:0]         lights,
    output logic [PH_W-1:0]               phase,
    output logic [1:0]                    state,
    output logic [TIMER_W-1:0]            timer,
    output logic [N_PHASES*CNT_W-1:0]     count_total,
    output logic [N_PHASES*QUEUE_W-1:0]   queue
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [N_PHASES-1:0]  detect_q, detect_d;
    logic [N_PHASES-1:0]  arrival;
    logic [QUEUE_W-1:0]   queue_q [N_PHASES];
    logic [QUEUE_W-1:0]   queue_d [N_PHASES];
    logic [CNT_W-1:0]     count_q [N_PHASES];
    logic [CNT_W-1:0]     count_d [N_PHASES];

    logic [PH_W-1:0]      rr_phase;
    logic                 rr_found;
    int                   rr_idx;
    logic [PH_W-1:0]      sel_phase;
    int                   green_sum;
    logic [TIMER_W-1:0]   green_load;
    logic                 green_exit;
    logic                 pre_cut;
    logic                 pre_hold;
    logic                 pre_sel;

    // Rising-edge arrival detection against the previous detector sample
    always_comb begin
        detect_d = detect;
        arrival  = detect & ~detect_q;
    end

    // Round-robin search for the next approach with waiting cars, phase itself last
    always_comb begin
        rr_phase = PH_W'((int'(phase_q) + 1) % N_PHASES);
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 1; k <= N_PHASES; k++) begin
            rr_idx = (int'(phase_q) + k) % N_PHASES;
            if (!rr_found && queue_q[rr_idx] != '0) begin
                rr_found = 1'b1;
                rr_phase = PH_W'(rr_idx);
            end
        end
    end

    // Preemption requests: cut a conflicting green short, freeze a matching one, steer the next pick
    always_comb begin
        pre_cut  = 1'b0;
        pre_hold = 1'b0;
        pre_sel  = 1'b0;
`ifdef PREEMPT_EN
        if (preempt && int'(preempt_phase) < N_PHASES) begin
            pre_sel = 1'b1;
            if (state_q == ST_GREEN) begin
                if (preempt_phase != phase_q) begin
                    pre_cut = 1'b1;
                end else begin
                    pre_hold = 1'b1;
                end
            end
        end
`endif
    end

    // Choose the approach to serve next and its queue-stretched, clamped green time
    always_comb begin
        sel_phase = rr_phase;
`ifdef PREEMPT_EN
        if (pre_sel) begin
            sel_phase = preempt_phase;
        end
`endif
        green_sum  = T_GREEN_MIN + T_PER_CAR * int'(queue_q[sel_phase]);
        green_load = TIMER_W'((green_sum > T_GREEN_MAX) ? T_GREEN_MAX : green_sum);
    end

    // Phase FSM: timer counts ticks down and each expiry advances GREEN -> YELLOW -> ALLRED -> GREEN
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        timer_d    = timer_q;
        green_exit = 1'b0;
        if (pre_cut) begin
            state_d    = ST_YELLOW;
            timer_d    = TIMER_W'(T_YELLOW);
            green_exit = 1'b1;
        end else if (tick && !pre_hold) begin
            if (timer_q <= TIMER_W'(1)) begin
                case (state_q)
                    ST_GREEN: begin
                        state_d    = ST_YELLOW;
                        timer_d    = TIMER_W'(T_YELLOW);
                        green_exit = 1'b1;
                    end
                    ST_YELLOW: begin
                        state_d = ST_ALLRED;
                        timer_d = TIMER_W'(T_ALLRED);
                    end
                    ST_ALLRED: begin
                        state_d = ST_GREEN;
                        phase_d = sel_phase;
                        timer_d = green_load;
                    end
                    default: begin
                        state_d = ST_ALLRED;
                        timer_d = TIMER_W'(T_ALLRED);
                    end
                endcase
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end
    end

    // Saturating arrival and queue counters; the served queue empties as its green ends
    always_comb begin
        for (int i = 0; i < N_PHASES; i++) begin
            count_d[i] = count_q[i];
            queue_d[i] = queue_q[i];
            if (arrival[i] && count_q[i] != '1) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end
            if (arrival[i] && queue_q[i] != '1) begin
                queue_d[i] = queue_q[i] + QUEUE_W'(1);
            end
            if (green_exit && PH_W'(i) == phase_q) begin
                queue_d[i] = arrival[i] ? QUEUE_W'(1) : '0;
            end
        end
    end

    // State register with synchronous reset to all-red clearance before approach 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ALLRED;
            phase_q  <= PH_W'(N_PHASES - 1);
            timer_q  <= TIMER_W'(T_ALLRED);
            detect_q <= '0;
            for (int i = 0; i < N_PHASES; i++) begin
                queue_q[i] <= '0;
                count_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            detect_q <= detect_d;
            for (int i = 0; i < N_PHASES; i++) begin
                queue_q[i] <= queue_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    // Output decode: only the active approach may leave red, and only in GREEN or YELLOW
    always_comb begin
        lights      = '0;
        queue       = '0;
        count_total = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            lights[3*i +: 3] = 3'b100;
            if (PH_W'(i) == phase_q) begin
                if (state_q == ST_GREEN) begin
                    lights[3*i +: 3] = 3'b001;
                end else if (state_q == ST_YELLOW) begin
                    lights[3*i +: 3] = 3'b010;
                end
            end
            queue[i*QUEUE_W +: QUEUE_W] = queue_q[i];
            count_total[i*CNT_W +: CNT_W] = count_q[i];
        end
        phase = phase_q;
        state = state_q;
        timer = timer_q;
    end

endmodule

// File: tb/tb_adaptive_intersection_ctrl.sv
// tb/tb_adaptive_intersection_ctrl.sv - scoreboard bench for adaptive_intersection_ctrl at default parameters
module tb_adaptive_intersection_ctrl;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [3:0]  detect;
`ifdef PREEMPT_EN
    logic        preempt;
    logic [1:0]  preempt_phase;
`endif
    logic [11:0] d_lights;
    logic [1:0]  d_phase;
    logic [1:0]  d_state;
    logic [5:0]  d_timer;
    logic [55:0] d_count;
    logic [19:0] d_queue;

    int nvec  = 0;
    int nfail = 0;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  ph;
        logic [5:0]  tm;
        logic [11:0] li;
        logic [19:0] qu;
        logic [55:0] ct;
    } exp_t;

    exp_t sb[$];

    int         m_state, m_phase, m_timer;
    int         m_q [N];
    int         m_c [N];
    logic [3:0] m_det;

    adaptive_intersection_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .detect       (detect),
`ifdef PREEMPT_EN
        .preempt      (preempt),
        .preempt_phase(preempt_phase),
`endif
        .lights       (d_lights),
        .phase        (d_phase),
        .state        (d_state),
        .timer        (d_timer),
        .count_total  (d_count),
        .queue        (d_queue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int   arr [N];
        int   oq  [N];
        int   np;
        bit   pcut;
        bit   phold;
        bit   psel;
        int   pph;
        exp_t e;
        pcut = 0; phold = 0; psel = 0; pph = 0;
        if (rst) begin
            m_state = 2; m_phase = 3; m_timer = 2; m_det = 4'b0;
            for (int i = 0; i < N; i++) begin m_q[i] = 0; m_c[i] = 0; end
        end else begin
            for (int i = 0; i < N; i++) begin
                oq[i]  = m_q[i];
                arr[i] = (detect[i] && !m_det[i]) ? 1 : 0;
                if (arr[i] == 1 && m_c[i] < 16383) m_c[i]++;
                if (arr[i] == 1 && m_q[i] < 31) m_q[i]++;
            end
`ifdef PREEMPT_EN
            if (preempt) begin
                psel = 1; pph = int'(preempt_phase);
                if (m_state == 0) begin
                    if (pph != m_phase) pcut = 1; else phold = 1;
                end
            end
`endif
            if (pcut) begin
                m_q[m_phase] = arr[m_phase];
                m_state = 1; m_timer = 4;
            end else if (tick && !phold) begin
                if (m_timer == 1) begin
                    if (m_state == 0) begin
                        m_q[m_phase] = arr[m_phase];
                        m_state = 1; m_timer = 4;
                    end else if (m_state == 1) begin
                        m_state = 2; m_timer = 2;
                    end else begin
                        np = -1;
                        for (int k = 1; k <= N; k++)
                            if (np < 0 && oq[(m_phase + k) % N] != 0) np = (m_phase + k) % N;
                        if (np < 0) np = (m_phase + 1) % N;
                        if (psel) np = pph;
                        m_state = 0; m_phase = np;
                        m_timer = (10 + 2 * oq[np] > 30) ? 30 : 10 + 2 * oq[np];
                    end
                end else begin
                    m_timer--;
                end
            end
            m_det = detect;
        end
        e.st = 2'(m_state);
        e.ph = 2'(m_phase);
        e.tm = 6'(m_timer);
        for (int i = 0; i < N; i++) begin
            if (i == m_phase && m_state == 0)      e.li[3*i +: 3] = 3'b001;
            else if (i == m_phase && m_state == 1) e.li[3*i +: 3] = 3'b010;
            else                                   e.li[3*i +: 3] = 3'b100;
            e.qu[5*i +: 5]   = 5'(m_q[i]);
            e.ct[14*i +: 14] = 14'(m_c[i]);
        end
        sb.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        e = sb.pop_front();
        chk("sb_state",  64'(d_state),  64'(e.st));
        chk("sb_phase",  64'(d_phase),  64'(e.ph));
        chk("sb_timer",  64'(d_timer),  64'(e.tm));
        chk("sb_lights", 64'(d_lights), 64'(e.li));
        chk("sb_queue",  64'(d_queue),  64'(e.qu));
        chk("sb_count",  64'(d_count),  64'(e.ct));
    endtask

    task automatic step(input logic r, input logic t, input logic [3:0] d);
        rst = r; tick = t; detect = d;
        model_step();
        @(posedge clk);
        #1;
        compare_pop();
        @(negedge clk);
    endtask

    task automatic tk(input int n, input logic [3:0] d);
        for (int j = 0; j < n; j++) begin
            step(1'b0, 1'b1, d);
            step(1'b0, 1'b0, d);
        end
    endtask

    task automatic pulses(input int n, input logic [3:0] d);
        for (int j = 0; j < n; j++) begin
            step(1'b0, 1'b0, d);
            step(1'b0, 1'b0, 4'b0);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},  64'(d_state),  64'd2);
        chk({tag, "_timer"},  64'(d_timer),  64'd2);
        chk({tag, "_phase"},  64'(d_phase),  64'd3);
        chk({tag, "_lights"}, 64'(d_lights), 64'h924);
        chk({tag, "_queue"},  64'(d_queue),  64'd0);
        chk({tag, "_count"},  64'(d_count),  64'd0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; detect = 4'b0;
`ifdef PREEMPT_EN
        preempt = 1'b0; preempt_phase = 2'd0;
`endif
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b1111);
        step(1'b1, 1'b0, 4'b0000);
        chk_reset("reset");

        tk(2, 4'b0);
        chk("first_green_phase", 64'(d_phase), 64'd0);
        chk("first_green_state", 64'(d_state), 64'd0);
        chk("first_green_timer", 64'(d_timer), 64'd10);

        tk(64, 4'b0);
        chk("rotation_phase", 64'(d_phase), 64'd0);
        chk("rotation_timer", 64'(d_timer), 64'd10);

        pulses(3, 4'b0010);
        chk("q1_after_3", 64'(d_queue[5 +: 5]),  64'd3);
        chk("c1_after_3", 64'(d_count[14 +: 14]), 64'd3);
        tk(16, 4'b0);
        chk("p1_green_phase", 64'(d_phase), 64'd1);
        chk("p1_green_timer", 64'(d_timer), 64'd16);
        tk(15, 4'b0);
        step(1'b0, 1'b1, 4'b0);
        chk("p1_exit_state", 64'(d_state), 64'd1);
        chk("p1_exit_queue", 64'(d_queue[5 +: 5]),  64'd0);
        chk("p1_exit_count", 64'(d_count[14 +: 14]), 64'd3);
        step(1'b0, 1'b0, 4'b0);

        tk(6, 4'b0);
        chk("p2_green_phase", 64'(d_phase), 64'd2);
        chk("p2_green_timer", 64'(d_timer), 64'd10);
        tk(9, 4'b0);
        step(1'b0, 1'b1, 4'b0100);
        chk("clear_arrival_queue", 64'(d_queue[10 +: 5]), 64'd1);
        chk("clear_arrival_state", 64'(d_state), 64'd1);
        tk(6, 4'b0);
        chk("p2_again_phase", 64'(d_phase), 64'd2);
        chk("p2_again_timer", 64'(d_timer), 64'd12);

        tk(34, 4'b0);
        chk("back_to_p0", 64'(d_phase), 64'd0);
        pulses(2, 4'b1000);
        tk(16, 4'b0);
        chk("skip_to_p3_phase", 64'(d_phase), 64'd3);
        chk("skip_to_p3_timer", 64'(d_timer), 64'd14);

        pulses(15, 4'b0100);
        tk(20, 4'b0);
        chk("clamp_phase", 64'(d_phase), 64'd2);
        chk("clamp_timer", 64'(d_timer), 64'd30);

        for (int j = 0; j < 100; j++) step(1'b0, 1'b0, 4'b0001);
        step(1'b0, 1'b0, 4'b0);
        chk("held_count0", 64'(d_count[0 +: 14]), 64'd1);
        chk("held_queue0", 64'(d_queue[0 +: 5]),  64'd1);

        pulses(40, 4'b0010);
        chk("sat_queue1", 64'(d_queue[5 +: 5]),   64'd31);
        chk("sat_count1", 64'(d_count[14 +: 14]), 64'd43);

        step(1'b1, 1'b1, 4'b1010);
        chk_reset("midrun_reset");

`ifdef PREEMPT_EN
        tk(2, 4'b0);
        tk(3, 4'b0);
        chk("pre_base_timer", 64'(d_timer), 64'd7);
        preempt = 1'b1; preempt_phase = 2'd2;
        step(1'b0, 1'b0, 4'b0);
        chk("pre_cut_state", 64'(d_state), 64'd1);
        chk("pre_cut_timer", 64'(d_timer), 64'd4);
        tk(6, 4'b0);
        chk("pre_sel_phase", 64'(d_phase), 64'd2);
        chk("pre_sel_state", 64'(d_state), 64'd0);
        chk("pre_sel_timer", 64'(d_timer), 64'd10);
        tk(5, 4'b0);
        chk("pre_hold_timer", 64'(d_timer), 64'd10);
        preempt = 1'b0;
        tk(1, 4'b0);
        chk("pre_release_timer", 64'(d_timer), 64'd9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
